serial_word_tx: RTL
===================

// Module: serial_word_tx
// PURPOSE
//  Parallel-to-serial framed word transmitter; transmit-side counterpart of the flex_stp_sr receive path.
//  Accepts one NUM_BITS word per valid/ready handshake; drives start bit (0), data bits, [parity], stop bit (1).
//  Each bit is held CLKS_PER_BIT clocks. Line idles high. Sits between the packet/control logic and the pad.
// PARAMETERS
//  NUM_BITS      8   data bits per frame (>=2)
//  SHIFT_MSB     0   1: MSB sent first; 0: LSB sent first
//  CLKS_PER_BIT  10  clocks per serial bit period (>=1)
// PORTS
//  clk         in   1         system clock, rising edge
//  rst         in   1         asynchronous reset, active-high
//  tx_data     in   NUM_BITS  word to send; sampled only on handshake
//  tx_valid    in   1         tx_data valid
//  tx_ready    out  1         block can accept a word
//  serial_out  out  1         serial line, idle high
//  tx_busy     out  1         frame in progress (START..STOP)
//  tx_done     out  1         1-cycle pulse after final stop-bit cycle
// BEHAVIOUR
//  Reset (async, immediate): serial_out=1, tx_ready=1, tx_busy=0, tx_done=0, state IDLE, all counters 0.
//  Handshake: tx_valid && tx_ready at edge T -> word captured at T; serial_out=0 from T+1 (1-cycle latency).
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; each bit state lasts exactly CLKS_PER_BIT cycles.
//  IDLE: tx_ready=1, tx_busy=0, serial_out=1. All other states: tx_ready=0, tx_busy=1.
//  DATA: NUM_BITS bits, order per SHIFT_MSB; bit counter width $clog2(NUM_BITS+1), no wrap.
//  Bit-period counter: width $clog2(CLKS_PER_BIT+1); reloads each bit; CLKS_PER_BIT=1 -> one cycle per bit.
//  STOP end: next cycle IDLE with tx_done=1 and tx_ready=1 together; one idle-high cycle minimum between frames.
//  tx_valid held high: next word accepted in that IDLE cycle; back-to-back frame period = frame_len+1 clocks.
//  tx_valid / tx_data changes while busy: ignored; captured word unaffected.
//  Reset mid-frame: frame aborted, line high immediately, no tx_done; next handshake starts a clean frame.
//  frame_len = (NUM_BITS+2)*CLKS_PER_BIT cycles (+CLKS_PER_BIT with parity).
// CONFIGURATION
//  SERIAL_TX_PARITY_EN defined: PARITY state after DATA sends even parity (^captured word), CLKS_PER_BIT cycles.
//  SERIAL_TX_PARITY_EN undefined: no PARITY state, logic absent; DATA goes directly to STOP.
// STRUCTURE
//  Package serial_tx_pkg: typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP}; IDLE_LEVEL=1'b1.
//  Sub-module flex_pts_sr (NUM_BITS, SHIFT_MSB): clk, rst, load_enable, shift_enable, parallel_in, serial_out.
//   Load has priority over shift. Shifts in 1s. Reset value all 1s.
//  Top level contains the FSM, the bit-period counter, the bit counter and the parity register.
// TESTING (NUM_BITS=8, CLKS_PER_BIT=4, SHIFT_MSB=0 unless stated; handshake edge = cycle 0)
//  1. rst=1 at any time -> serial_out=1, tx_ready=1, tx_busy=0, tx_done=0 immediately.
//  2. Send 0xA5 -> start 0 in cycles 1-4. Data 1,0,1,0,0,1,0,1 in cycles 5-36.
//     Stop 1 in cycles 37-40. tx_done=1 and tx_ready=1 in cycle 41 only.
//  3. SHIFT_MSB=1, send 0x80 -> first data bit 1 (cycles 5-8), then seven 0 bits, stop 1.
//  4. tx_valid held, 0x00 then 0xFF; pulse tx_valid with 0x12 during busy -> second start at cycle 42.
//     0x12 never sent.
//  5. Send 0x3C, rst pulse at cycle 10 -> serial_out=1 at once, no tx_done.
//     Re-send 0x3C -> correct full frame.
//  6. SERIAL_TX_PARITY_EN defined, send 0x07 -> parity bit 1 in cycles 37-40.
//     Stop in cycles 41-44. tx_done in cycle 45.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types for the serial word transmitter.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Level driven on the line whenever no frame is in flight
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register. Load wins over shift, vacated bits fill with 1s
// so that an over-shifted register naturally presents the idle level.
module flex_pts_sr #(
    parameter int NUM_BITS  = 8,
    parameter int SHIFT_MSB = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_enable,
    input  logic                shift_enable,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                serial_out
);

    logic [NUM_BITS-1:0] sr;

    // Capture a new word or advance by one bit toward the output end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '1;
        end else if (load_enable) begin
            sr <= parallel_in;
        end else if (shift_enable) begin
            if (SHIFT_MSB != 0) begin
                sr <= {sr[NUM_BITS-2:0], 1'b1};
            end else begin
                sr <= {1'b1, sr[NUM_BITS-1:1]};
            end
        end
    end

    assign serial_out = (SHIFT_MSB != 0) ? sr[NUM_BITS-1] : sr[0];

endmodule

// File: rtl/serial_word_tx.sv
// Framed parallel-to-serial word transmitter: start(0), data, optional parity, stop(1).
// Optional even-parity bit enabled by defining SERIAL_TX_PARITY_EN.
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | driving start bit (0)
// DATA   | driving NUM_BITS data bits from the shift register
// PARITY | driving even parity of the captured word (optional)
// STOP   | driving stop bit (1); tx_done pulses on exit
module serial_word_tx
    import serial_tx_pkg::*;
#(
    parameter int NUM_BITS     = 8,
    parameter int SHIFT_MSB    = 0,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                serial_out,
    output logic                tx_busy,
    output logic                tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(NUM_BITS + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_LOAD = BW'(NUM_BITS);

    tx_state_t     state;
    logic [CW-1:0] clk_cnt;
    logic [BW-1:0] bit_cnt;
    logic          sr_out;
    logic          load_en;
    logic          shift_en;
    logic          bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic          parity_q;
`endif

    assign bit_end  = (clk_cnt == CW'(1));
    assign load_en  = tx_valid && tx_ready;
    // Shift on every transition into the next data bit so sr_out always holds the upcoming bit
    assign shift_en = bit_end && ((state == START) || (state == DATA));

    flex_pts_sr #(
        .NUM_BITS  (NUM_BITS),
        .SHIFT_MSB (SHIFT_MSB)
    ) u_pts_sr (
        .clk          (clk),
        .rst          (rst),
        .load_enable  (load_en),
        .shift_enable (shift_en),
        .parallel_in  (tx_data),
        .serial_out   (sr_out)
    );

    // Frame sequencer with bit-period and bit counters; all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            serial_out <= IDLE_LEVEL;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_en) begin
                        state      <= START;
                        clk_cnt    <= CNT_LOAD;
                        serial_out <= 1'b0;
                        tx_ready   <= 1'b0;
                        tx_busy    <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                        parity_q   <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state      <= DATA;
                        clk_cnt    <= CNT_LOAD;
                        bit_cnt    <= BIT_LOAD;
                        serial_out <= sr_out;
                    end else begin
                        clk_cnt <= clk_cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= CNT_LOAD;
                        bit_cnt <= bit_cnt - BW'(1);
                        if (bit_cnt == BW'(1)) begin
`ifdef SERIAL_TX_PARITY_EN
                            state      <= PARITY;
                            serial_out <= parity_q;
`else
                            state      <= STOP;
                            serial_out <= IDLE_LEVEL;
`endif
                        end else begin
                            serial_out <= sr_out;
                        end
                    end else begin
                        clk_cnt <= clk_cnt - CW'(1);
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state      <= STOP;
                        clk_cnt    <= CNT_LOAD;
                        serial_out <= IDLE_LEVEL;
                    end else begin
                        clk_cnt <= clk_cnt - CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state      <= IDLE;
                        clk_cnt    <= '0;
                        serial_out <= IDLE_LEVEL;
                        tx_ready   <= 1'b1;
                        tx_busy    <= 1'b0;
                        tx_done    <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt - CW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    clk_cnt    <= '0;
                    bit_cnt    <= '0;
                    serial_out <= IDLE_LEVEL;
                    tx_ready   <= 1'b1;
                    tx_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
